// File: rtl/dbg_pkg.sv
// Shared encodings for the CPU debug/run controller: command codes,
// run states and halt causes.
package dbg_pkg;

    localparam int unsigned CMD_W = 3;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned PC_W  = 32;

    localparam logic [CMD_W-1:0] CMD_NOP     = 3'd0;
    localparam logic [CMD_W-1:0] CMD_RUN     = 3'd1;
    localparam logic [CMD_W-1:0] CMD_STEP    = 3'd2;
    localparam logic [CMD_W-1:0] CMD_HALT    = 3'd3;
    localparam logic [CMD_W-1:0] CMD_BP_SET  = 3'd4;
    localparam logic [CMD_W-1:0] CMD_BP_CLR  = 3'd5;
    localparam logic [CMD_W-1:0] CMD_CNT_CLR = 3'd6;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_CMD  = 2'd0,
        CAUSE_BP   = 2'd1,
        CAUSE_STOP = 2'd2,
        CAUSE_STEP = 2'd3
    } cause_t;

endpackage

// File: rtl/bp_match.sv
// PC breakpoint register file with a lowest-index-wins match against the
// current core PC. Writes land next cycle, so a same-cycle match sees old data.
module bp_match
    import dbg_pkg::*;
#(
    parameter int unsigned NBP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_set,
    input  logic             wr_clr,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PC_W-1:0]  wr_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             hit_c,
    output logic [IDX_W-1:0] hit_idx_c
);

    logic [PC_W-1:0] r_bp_addr [NBP];
    logic [NBP-1:0]  r_bp_vld;

    // Indices at or above NBP never compare equal, so such writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_vld <= '0;
            for (int i = 0; i < int'(NBP); i++) begin
                r_bp_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBP); i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    if (wr_set) begin
                        r_bp_vld[i]  <= 1'b1;
                        r_bp_addr[i] <= wr_addr;
                    end else if (wr_clr) begin
                        r_bp_vld[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = int'(NBP) - 1; i >= 0; i--) begin
            if (r_bp_vld[i] && (r_bp_addr[i] == pc)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_dbg_ctrl.sv
// Debug/run controller: gates core progress with cpu_en, handles run/step/halt,
// PC breakpoints and core stop, grants the debug port while halted, counts cycles.
module cpu_dbg_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned NBP = 4,
    parameter int unsigned CW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [2:0]       cmd_idx,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      pc,
    input  logic             ir_load,
    input  logic             core_stop,
    output logic             cpu_en,
    input  logic             dbg_req,
    output logic             dbg_gnt,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [2:0]       bp_hit_idx,
    output logic [CW-1:0]    cycle_cnt,
    output logic [CW-1:0]    inst_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    cause_t           r_cause;
    cause_t           w_cause_nxt;
    logic [IDX_W-1:0] r_bp_hit_idx;
    logic [IDX_W-1:0] w_hit_idx_nxt;
    logic             r_skip_bp;
    logic             w_skip_nxt;
    logic             r_step_seen;
    logic             w_step_seen_nxt;
    logic             r_halt_pend;
    logic             w_halt_pend_nxt;
    logic             r_dbg_gnt;
    logic [CW-1:0]    r_cycle_cnt;
    logic [CW-1:0]    r_inst_cnt;

    logic             w_cpu_en;
    logic             w_bp_hit;
    logic [IDX_W-1:0] w_bp_idx;
    logic             w_bp_stop;
    logic             w_halt_at;
    logic             w_step_done;

    // Run/step requests are swallowed while the debug port owns the core.
    logic w_cmd_run, w_cmd_step, w_cmd_halt, w_cmd_set, w_cmd_clr, w_cmd_cnt_clr;
    assign w_cmd_run     = cmd_valid && (cmd == CMD_RUN)  && !r_dbg_gnt;
    assign w_cmd_step    = cmd_valid && (cmd == CMD_STEP) && !r_dbg_gnt;
    assign w_cmd_halt    = cmd_valid && (cmd == CMD_HALT);
    assign w_cmd_set     = cmd_valid && (cmd == CMD_BP_SET);
    assign w_cmd_clr     = cmd_valid && (cmd == CMD_BP_CLR);
    assign w_cmd_cnt_clr = cmd_valid && (cmd == CMD_CNT_CLR);

    bp_match #(
        .NBP (NBP)
    ) u_bp_match (
        .clk       (clk),
        .rst       (rst),
        .wr_set    (w_cmd_set),
        .wr_clr    (w_cmd_clr),
        .wr_idx    (cmd_idx),
        .wr_addr   (cmd_addr),
        .pc        (pc),
        .hit_c     (w_bp_hit),
        .hit_idx_c (w_bp_idx)
    );

    // Next-state and core enable; stop priority is core_stop > breakpoint > halt.
    always_comb begin
        w_state_nxt     = r_state;
        w_cause_nxt     = r_cause;
        w_hit_idx_nxt   = r_bp_hit_idx;
        w_skip_nxt      = r_skip_bp;
        w_step_seen_nxt = r_step_seen;
        w_halt_pend_nxt = r_halt_pend;
        w_cpu_en        = 1'b0;
        w_bp_stop       = 1'b0;
        w_halt_at       = 1'b0;
        w_step_done     = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (w_cmd_run) begin
                    w_state_nxt = ST_RUN;
                    w_skip_nxt  = 1'b1;
                end else if (w_cmd_step) begin
                    w_state_nxt     = ST_STEP;
                    w_step_seen_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                w_bp_stop = ir_load && !r_skip_bp && w_bp_hit;
                w_halt_at = ir_load && (r_halt_pend || w_cmd_halt);
                w_cpu_en  = !(w_bp_stop || w_halt_at);
                if (ir_load) begin
                    w_skip_nxt = 1'b0;
                end
                if (w_cmd_halt) begin
                    w_halt_pend_nxt = 1'b1;
                end
                if (core_stop) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_STOP;
                end else if (w_bp_stop) begin
                    w_state_nxt   = ST_HALT;
                    w_cause_nxt   = CAUSE_BP;
                    w_hit_idx_nxt = w_bp_idx;
                end else if (w_halt_at) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_CMD;
                end
            end
            ST_STEP: begin
                // Entry fetch loads the instruction; the next fetch ends the step.
                w_step_done = ir_load && r_step_seen;
                w_cpu_en    = !w_step_done;
                if (ir_load) begin
                    w_step_seen_nxt = 1'b1;
                end
                if (core_stop) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_STOP;
                end else if (w_step_done) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_STEP;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
        if (w_state_nxt == ST_HALT) begin
            w_halt_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_HALT;
            r_cause      <= CAUSE_CMD;
            r_bp_hit_idx <= '0;
            r_skip_bp    <= 1'b0;
            r_step_seen  <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_dbg_gnt    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cause      <= w_cause_nxt;
            r_bp_hit_idx <= w_hit_idx_nxt;
            r_skip_bp    <= w_skip_nxt;
            r_step_seen  <= w_step_seen_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
            r_dbg_gnt    <= dbg_req && (w_state_nxt == ST_HALT);
        end
    end

    // Clear beats a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else if (w_cmd_cnt_clr) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else begin
            if (w_cpu_en) begin
                r_cycle_cnt <= r_cycle_cnt + CW'(1);
            end
            if (w_cpu_en && ir_load) begin
                r_inst_cnt <= r_inst_cnt + CW'(1);
            end
        end
    end

    assign cpu_en     = w_cpu_en && !rst;
    assign dbg_gnt    = r_dbg_gnt;
    assign state      = r_state;
    assign halt_cause = r_cause;
    assign bp_hit_idx = r_bp_hit_idx;
    assign cycle_cnt  = r_cycle_cnt;
    assign inst_cnt   = r_inst_cnt;

endmodule

// File: doc/cpu_dbg_ctrl.md
Name: cpu_dbg_ctrl

Overview:
Debug/run controller for the multicycle CPU core. Gates core progress through a clock-enable and supports run, single-step, halt, four PC breakpoints and the core's own stop signal. While the core is halted, it grants the debug port exclusive access to instruction memory, data memory and the register file. It also keeps cycle and retired-instruction counters for the debug display.

Parameters:
NBP, 4, number of PC breakpoint registers (1..8)
CW, 32, width of cycle and instruction counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  one-cycle command strobe
cmd  input  3  0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 BP_SET, 5 BP_CLR, 6 CNT_CLR
cmd_idx  input  3  breakpoint index for BP_SET/BP_CLR
cmd_addr  input  32  breakpoint PC for BP_SET
pc  input  32  core PC
ir_load  input  1  core fetch cycle; marks the instruction boundary
core_stop  input  1  core stop (halt instruction decoded)
cpu_en  output  1  core advance enable (combinational, see rules)
dbg_req  input  1  debug access request (inst/data/rf)
dbg_gnt  output  1  debug access granted
state  output  2  0 HALT, 1 RUN, 2 STEP
halt_cause  output  2  0 reset/cmd, 1 breakpoint, 2 stop, 3 step done
bp_hit_idx  output  3  index of the last breakpoint hit
cycle_cnt  output  CW  cycles with cpu_en=1
inst_cnt  output  CW  fetches with cpu_en=1

Behaviour:
- Reset (async, rst=1): state=HALT, halt_cause=0, all breakpoints invalid, counters=0, bp_hit_idx=0, dbg_gnt=0, skip_bp=0, step_seen=0. The core is released from reset at its fetch boundary, so HALT always holds the core at an ir_load cycle.
- HALT:
  - cpu_en=0.
  - RUN → state RUN, skip_bp=1.
  - STEP → state STEP, step_seen=0.
  - HALT/NOP → no effect.
- RUN:
  - cpu_en=1, except in a stop cycle.
  - Stop cycle: ir_load=1, skip_bp=0 and pc equals any valid bp[i]. Then cpu_en=0 combinationally; next state HALT; cause=1; bp_hit_idx = lowest matching i.
  - ir_load with skip_bp=1 clears skip_bp and does not break. This lets RUN resume from a breakpoint PC.
  - core_stop=1 → HALT next cycle, cause=2, cpu_en still 1 that cycle.
  - HALT command: the core continues to the next ir_load, where cpu_en=0, state HALT, cause=0.
- STEP:
  - cpu_en=1 until the second ir_load. The first ir_load, in the entry cycle, fetches the instruction and sets step_seen.
  - On ir_load with step_seen=1: cpu_en=0, state HALT, cause=3.
  - Breakpoints are ignored in STEP.
  - core_stop → HALT, cause=2.
  - A HALT command during STEP is ignored; the step completes.
- Priority within one cycle: core_stop > breakpoint > HALT command. A RUN/STEP command outside HALT is ignored.
- BP_SET/BP_CLR are accepted in any state and take effect next cycle. A write to an index ≥ NBP is ignored. A match in the same cycle uses the old value.
- CNT_CLR: both counters go to 0 next cycle. If it coincides with an increment, the clear wins.
- Counters wrap modulo 2^CW.
- Arbitration:
  - dbg_gnt is registered: dbg_gnt <= dbg_req & (next state==HALT).
  - Any RUN/STEP command is blocked while dbg_gnt=1. The command is dropped, not queued.
  - The grant drops the cycle after dbg_req falls.
  - Debug writes to the RF or memories are legal only while dbg_gnt=1. This is enforced by the top-level AND of the debug write enables with dbg_gnt.
- Reset mid-step or mid-run: all state returns to reset values immediately. cpu_en=0 while rst=1.

Decomposition:
- Package dbg_pkg holds:
  - cmd encodings (CMD_NOP..CMD_CNT_CLR)
  - state encodings (ST_HALT, ST_RUN, ST_STEP)
  - halt_cause encodings
- One sub-module, bp_match: NBP valid/address registers plus a priority match producing hit and hit_idx.

Test Plan:
- Reset then RUN: pc sequence 0,4,8 with ir_load every 3 cycles; core_stop at cycle 20 → state=HALT next cycle, cause=2; cycle_cnt=21 counted over cycles 0..20, the stop cycle included; inst_cnt=7.
- BP_SET idx 1 at 0x0000_000C, then RUN → cpu_en=0 on the fetch with pc=0x0C; bp_hit_idx=1, cause=1; a second RUN fetches 0x0C and does not re-break.
- STEP from HALT at pc=0 with a 3-cycle instruction → cpu_en=1 for exactly 3 cycles and 0 on the fetch at pc=4; cause=3; inst_cnt +1.
- dbg_req held in HALT → dbg_gnt=1 one cycle later; RUN issued during the grant is ignored (state stays HALT); dbg_req drop → dbg_gnt=0 next cycle.
- Simultaneous: breakpoint match and HALT command on the same fetch → cause=1; core_stop together with CNT_CLR → counters=0, cause=2.
- rst asserted mid-STEP → cpu_en=0 and state=HALT immediately; breakpoints invalid; counters=0.
